// File: rtl/y86_elastic_pipe_reg.sv
// Elastic two-entry pipeline-stage register (main + skid) for the Y86 pipeline.
// Presents BUBBLE_VALUE downstream whenever it holds nothing; flush discards all held entries.
module y86_elastic_pipe_reg #(
    parameter int unsigned      WIDTH        = 212,
    parameter logic [WIDTH-1:0] BUBBLE_VALUE = {WIDTH{1'b0}}
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             in_valid_i,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             in_ready_o,
    output logic             out_valid_o,
    output logic [WIDTH-1:0] out_data_o,
    input  logic             out_ready_i,
    output logic [1:0]       occupancy_o
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             in_ready_s;
    logic             out_valid_s;
    logic             accept_s;
    logic             emit_s;

    // Handshake flags are decoded from the state flops only, so out_ready_i never reaches in_ready_o.
    assign in_ready_s  = (state_q == ST_EMPTY) || (state_q == ST_ONE);
    assign out_valid_s = (state_q == ST_ONE) || (state_q == ST_TWO);
    assign accept_s    = in_valid_i & in_ready_s;
    assign emit_s      = out_valid_s & out_ready_i;

    assign in_ready_o  = in_ready_s;
    assign out_valid_o = out_valid_s;
    assign occupancy_o = state_q;
    // main_q is forced to BUBBLE_VALUE whenever the block drains, so it can drive the output directly.
    assign out_data_o  = main_q;

    // Next-state and payload steering; flush overrides every other transition.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush_i) begin
            state_d = ST_EMPTY;
            main_d  = BUBBLE_VALUE;
            skid_d  = BUBBLE_VALUE;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept_s) begin
                        state_d = ST_ONE;
                        main_d  = in_data_i;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (accept_s && emit_s) begin
                        state_d = ST_ONE;
                        main_d  = in_data_i;
                    end else if (accept_s) begin
                        state_d = ST_TWO;
                        skid_d  = in_data_i;
                    end else if (emit_s) begin
                        state_d = ST_EMPTY;
                        main_d  = BUBBLE_VALUE;
                    end else begin
                        state_d = ST_ONE;
                    end
                end
                ST_TWO: begin
                    if (emit_s) begin
                        state_d = ST_ONE;
                        main_d  = skid_q;
                        skid_d  = BUBBLE_VALUE;
                    end else begin
                        state_d = ST_TWO;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                    main_d  = BUBBLE_VALUE;
                    skid_d  = BUBBLE_VALUE;
                end
            endcase
        end
    end

    // State and payload registers with asynchronous reset to the bubble.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_EMPTY;
            main_q  <= BUBBLE_VALUE;
            skid_q  <= BUBBLE_VALUE;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

endmodule
